// File: rtl/calc_key_sequencer_if.sv
// Operand/key inputs and result/status outputs of the key calculator controller.
// The master side drives switches and keys; the slave side is the controller.
interface calc_key_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] sw;
    logic [3:0]       key;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             op_sub;
    logic             result_valid;
    logic [1:0]       state;
    logic [7:0]       disp_blank;

    modport master (
        output sw, key,
        input  operand_a, operand_b, result, carry, op_sub, result_valid, state, disp_blank
    );

    modport slave (
        input  sw, key,
        output operand_a, operand_b, result, carry, op_sub, result_valid, state, disp_blank
    );
endinterface

// File: rtl/calc_key_sequencer.sv
// Key debouncer plus operand/result sequencer for the switch/key calculator.
// Keys: [3]=ENTER, [2]=ACCUM, [1]=CLEAR, [0]=OP toggle.
module calc_key_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned WIDTH           = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    calc_key_sequencer_if.slave bus
);
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [7:0] BLANK_IDLE   = 8'b0011_1111;
    localparam logic [7:0] BLANK_HAVE_A = 8'b0000_0111;
    localparam logic [7:0] BLANK_RESULT = 8'b0000_0000;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StHaveA   = 2'd1,
        StResult  = 2'd2,
        StIllegal = 2'd3
    } state_e;

    // Key synchroniser, debounce counters and press pulses.
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_level;
    logic [3:0]       r_press;
    logic [CNT_W-1:0] r_cnt [4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            r_press <= '0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= bus.key;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 4; i++) begin
                r_press[i] <= 1'b0;
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_cnt[i]   <= '0;
                    r_level[i] <= r_sync2[i];
                    r_press[i] <= r_sync2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Only the highest-priority event of a cycle acts: CLEAR > ENTER > ACCUM > OP.
    logic w_ev_clr;
    logic w_ev_ent;
    logic w_ev_acc;
    logic w_ev_op;

    assign w_ev_clr = r_press[1];
    assign w_ev_ent = r_press[3] & ~r_press[1];
    assign w_ev_acc = r_press[2] & ~r_press[3] & ~r_press[1];
    assign w_ev_op  = r_press[0] & ~(|r_press[3:1]);

    function automatic logic [WIDTH:0] alu(input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y,
                                           input logic             sub);
        // Bit WIDTH is carry for add and borrow (x < y) for subtract.
        return sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    endfunction

    function automatic logic [7:0] blank_for(input state_e s);
        case (s)
            StHaveA:  return BLANK_HAVE_A;
            StResult: return BLANK_RESULT;
            default:  return BLANK_IDLE;
        endcase
    endfunction

    state_e           r_state;
    state_e           w_state_d;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_op_sub;
    logic             r_valid;
    logic [7:0]       r_blank;
    logic [WIDTH-1:0] w_a_d;
    logic [WIDTH-1:0] w_b_d;
    logic [WIDTH-1:0] w_result_d;
    logic             w_carry_d;
    logic             w_op_sub_d;
    logic             w_valid_d;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_d = r_state;
        if (w_ev_clr) begin
            w_state_d = StIdle;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_ev_ent) w_state_d = StHaveA;
                end
                StHaveA: begin
                    if (w_ev_ent) w_state_d = StResult;
                end
                StResult: begin
                    if (w_ev_ent || w_ev_acc) w_state_d = StHaveA;
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    // Datapath next values driven by the current state and event.
    always_comb begin
        w_a_d      = r_a;
        w_b_d      = r_b;
        w_result_d = r_result;
        w_carry_d  = r_carry;
        w_op_sub_d = r_op_sub;
        w_valid_d  = 1'b0;
        if (w_ev_clr || (r_state == StIllegal)) begin
            w_a_d      = '0;
            w_b_d      = '0;
            w_result_d = '0;
            w_carry_d  = 1'b0;
            w_op_sub_d = 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_ev_ent) w_a_d = bus.sw;
                    if (w_ev_op)  w_op_sub_d = ~r_op_sub;
                end
                StHaveA: begin
                    if (w_ev_ent) begin
                        w_b_d                   = bus.sw;
                        {w_carry_d, w_result_d} = alu(r_a, bus.sw, r_op_sub);
                        w_valid_d               = 1'b1;
                    end
                    if (w_ev_op) w_op_sub_d = ~r_op_sub;
                end
                StResult: begin
                    if (w_ev_ent) begin
                        w_a_d = bus.sw;
                        w_b_d = '0;
                    end
                    if (w_ev_acc) begin
                        w_a_d = r_result;
                        w_b_d = '0;
                    end
                    if (w_ev_op) begin
                        w_op_sub_d              = ~r_op_sub;
                        {w_carry_d, w_result_d} = alu(r_a, r_b, ~r_op_sub);
                        w_valid_d               = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_op_sub <= 1'b0;
            r_valid  <= 1'b0;
            r_blank  <= BLANK_IDLE;
        end else begin
            r_a      <= w_a_d;
            r_b      <= w_b_d;
            r_result <= w_result_d;
            r_carry  <= w_carry_d;
            r_op_sub <= w_op_sub_d;
            r_valid  <= w_valid_d;
            r_blank  <= blank_for(w_state_d);
        end
    end

    assign bus.operand_a    = r_a;
    assign bus.operand_b    = r_b;
    assign bus.result       = r_result;
    assign bus.carry        = r_carry;
    assign bus.op_sub       = r_op_sub;
    assign bus.result_valid = r_valid;
    assign bus.state        = r_state;
    assign bus.disp_blank   = r_blank;
endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed bench for calc_key_sequencer with DEBOUNCE_CYCLES=4.
module tb_calc_key_sequencer;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic pv1;
    logic pv2;

    calc_key_sequencer_if #(.WIDTH(8)) bus_if ();

    calc_key_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .WIDTH          (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Raise keys, capture result_valid in the action cycle and the one after, then release.
    task automatic press(input logic [3:0] mask);
        bus_if.key = mask;
        repeat (7) @(negedge clk);
        pv1 = bus_if.result_valid;
        @(negedge clk);
        pv2 = bus_if.result_valid;
        bus_if.key = 4'b0000;
        repeat (8) @(negedge clk);
    endtask

    task automatic chk_regs(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] res, input logic c, input logic sub,
                            input logic [1:0] st);
        chk({tag, ".a"}, 32'(bus_if.operand_a), 32'(a));
        chk({tag, ".b"}, 32'(bus_if.operand_b), 32'(b));
        chk({tag, ".result"}, 32'(bus_if.result), 32'(res));
        chk({tag, ".carry"}, 32'(bus_if.carry), 32'(c));
        chk({tag, ".op_sub"}, 32'(bus_if.op_sub), 32'(sub));
        chk({tag, ".state"}, 32'(bus_if.state), 32'(st));
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst_n      = 1'b0;
        bus_if.sw  = 8'h00;
        bus_if.key = 4'b0000;
        repeat (2) @(negedge clk);
        chk_regs("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
        chk("reset.valid", 32'(bus_if.result_valid), 32'd0);
        chk("reset.blank", 32'(bus_if.disp_blank), 32'h3F);
        rst_n = 1'b1;
        @(negedge clk);

        // Exact latency: event in cycle 6, action at the 7th edge.
        bus_if.sw  = 8'h25;
        bus_if.key = 4'b1000;
        repeat (6) @(negedge clk);
        chk("lat.before", 32'(bus_if.state), 32'd0);
        @(negedge clk);
        chk("lat.state", 32'(bus_if.state), 32'd1);
        chk("lat.a", 32'(bus_if.operand_a), 32'h25);
        chk("lat.blank", 32'(bus_if.disp_blank), 32'h07);
        chk("lat.valid", 32'(bus_if.result_valid), 32'd0);
        repeat (20) @(negedge clk);
        chk("hold.state", 32'(bus_if.state), 32'd1);
        bus_if.key = 4'b0000;
        repeat (8) @(negedge clk);

        // 3-cycle glitch on ENTER must be ignored.
        bus_if.sw  = 8'h77;
        bus_if.key = 4'b1000;
        repeat (3) @(negedge clk);
        bus_if.key = 4'b0000;
        repeat (10) @(negedge clk);
        chk_regs("glitch", 8'h25, 8'h00, 8'h00, 1'b0, 1'b0, 2'd1);

        bus_if.sw = 8'h13;
        press(4'b1000);
        chk_regs("add", 8'h25, 8'h13, 8'h38, 1'b0, 1'b0, 2'd2);
        chk("add.valid", 32'(pv1), 32'd1);
        chk("add.valid_once", 32'(pv2), 32'd0);
        chk("add.blank", 32'(bus_if.disp_blank), 32'h00);

        press(4'b0001);
        chk_regs("op_sub", 8'h25, 8'h13, 8'h12, 1'b0, 1'b1, 2'd2);
        chk("op_sub.valid", 32'(pv1), 32'd1);

        press(4'b0001);
        chk_regs("op_add", 8'h25, 8'h13, 8'h38, 1'b0, 1'b0, 2'd2);

        press(4'b0100);
        chk_regs("accum", 8'h38, 8'h00, 8'h38, 1'b0, 1'b0, 2'd1);
        chk("accum.valid", 32'(pv1), 32'd0);
        chk("accum.blank", 32'(bus_if.disp_blank), 32'h07);

        bus_if.sw = 8'h08;
        press(4'b1000);
        chk_regs("acc_add", 8'h38, 8'h08, 8'h40, 1'b0, 1'b0, 2'd2);

        press(4'b0010);
        chk_regs("clear", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
        chk("clear.valid", 32'(pv1), 32'd0);
        chk("clear.blank", 32'(bus_if.disp_blank), 32'h3F);

        // Subtract with borrow, then flip to add.
        press(4'b0001);
        chk("idle_op", 32'(bus_if.op_sub), 32'd1);
        bus_if.sw = 8'h10;
        press(4'b1000);
        bus_if.sw = 8'h20;
        press(4'b1000);
        chk_regs("borrow", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b1, 2'd2);
        press(4'b0001);
        chk_regs("borrow_add", 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 2'd2);

        press(4'b0010);
        bus_if.sw = 8'hF0;
        press(4'b1000);
        bus_if.sw = 8'h20;
        press(4'b1000);
        chk_regs("carry", 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 2'd2);

        bus_if.sw = 8'h55;
        press(4'b1000);
        chk_regs("re_enter", 8'h55, 8'h00, 8'h10, 1'b1, 1'b0, 2'd1);
        chk("re_enter.valid", 32'(pv1), 32'd0);

        // ENTER and CLEAR together in HAVE_A: CLEAR wins.
        press(4'b1010);
        chk_regs("prio", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
        chk("prio.valid", 32'(pv1), 32'd0);

        press(4'b0100);
        chk_regs("idle_acc", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);

        // Reset mid-debounce with key released: pending count is lost.
        bus_if.key = 4'b0001;
        repeat (3) @(negedge clk);
        rst_n      = 1'b0;
        bus_if.key = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("rst_drop.op_sub", 32'(bus_if.op_sub), 32'd0);

        // Reset mid-debounce with key held: full latency restarts from reset.
        bus_if.key = 4'b0001;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_hold.before", 32'(bus_if.op_sub), 32'd0);
        @(negedge clk);
        chk("rst_hold.op_sub", 32'(bus_if.op_sub), 32'd1);
        bus_if.key = 4'b0000;
        repeat (8) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
